// File: rtl/store_drain_buffer_pkg.sv
// store_buf_pkg: shared types and defaults for the store drain buffer.
//   SB_DATA / SB_ADDR / SB_DEPTH : default data width, word address width, entries
//   sb_entry_t                   : canonical {addr, data} layout of one pending store
//   sb_ptr_w()                   : FIFO pointer width for a given depth
package store_buf_pkg;

    localparam int SB_DATA  = 32;
    localparam int SB_ADDR  = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [SB_ADDR-1:0] addr;
        logic [SB_DATA-1:0] data;
    } sb_entry_t;

    // Pointer width; kept at least 1 so a degenerate depth still elaborates.
    function automatic int sb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_drain_buffer_fwd_match.sv
// sb_fwd_match: combinational load-forwarding search over the store buffer.
//   entry_addr/entry_data : storage array, indexed by physical slot
//   head, count           : oldest slot and number of valid entries
//   ld_addr               : load word address to look up
//   hit, data             : youngest valid match; data is 0 when hit=0
module sb_fwd_match
    import store_buf_pkg::*;
#(
    parameter int DATA  = SB_DATA,
    parameter int ADDR  = SB_ADDR,
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = sb_ptr_w(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR-1:0] entry_addr,
    input  logic [DEPTH-1:0][DATA-1:0] entry_data,
    input  logic [PW-1:0]              head,
    input  logic [CW-1:0]              count,
    input  logic [ADDR-1:0]            ld_addr,
    output logic                       hit,
    output logic [DATA-1:0]            data
);

    // Compare in age order: age 0 is the head (oldest), age count-1 the youngest.
    logic [DEPTH-1:0][PW-1:0] age_idx;
    logic [DEPTH-1:0]         age_match;

    for (genvar a = 0; a < DEPTH; a++) begin : g_age
        assign age_idx[a]   = head + PW'(a);
        assign age_match[a] = (CW'(a) < count) && (entry_addr[age_idx[a]] == ld_addr);
    end

    // Later ages overwrite earlier ones, so the youngest match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (age_match[a]) begin
                hit  = 1'b1;
                data = entry_data[age_idx[a]];
            end
        end
    end

endmodule

// File: rtl/store_drain_buffer.sv
// store_drain_buffer: write-through store FIFO draining into a single-port data memory.
//   clk, rst                    : clock, synchronous active-high reset
//   st_valid/st_addr/st_data    : store request; held stable by the core while stall=1
//   stall                       : store cannot be accepted this cycle
//   ld_addr, fwd_hit, fwd_data  : combinational forwarding lookup for loads
//   mem_grant                   : memory port free for a write this cycle
//   mem_WE/mem_A/mem_WD         : write port to data memory, showing the head entry
//   empty, count                : occupancy
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into the youngest
// entry when the word address matches.
module store_drain_buffer
    import store_buf_pkg::*;
#(
    parameter int DATA  = SB_DATA,
    parameter int ADDR  = SB_ADDR,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    input  logic [ADDR-1:0]              st_addr,
    input  logic [DATA-1:0]              st_data,
    output logic                         stall,
    input  logic [ADDR-1:0]              ld_addr,
    output logic                         fwd_hit,
    output logic [DATA-1:0]              fwd_data,
    input  logic                         mem_grant,
    output logic                         mem_WE,
    output logic [ADDR-1:0]              mem_A,
    output logic [DATA-1:0]              mem_WD,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = sb_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ADDR-1:0] addr_q;
    logic [DEPTH-1:0][DATA-1:0] data_q;
    logic [PW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q;

    logic full, push;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;

    // Head is always visible on the port; the write only fires on grant.
    assign mem_WE = !empty && mem_grant;
    assign mem_A  = addr_q[head_q];
    assign mem_WD = data_q[head_q];

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] last_idx;
    logic          coalescable, coal;

    assign last_idx = tail_q - PW'(1);
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign coalescable = !empty && (addr_q[last_idx] == st_addr)
                         && !(mem_WE && count_q == CW'(1));
    assign stall = full && !(st_valid && coalescable);
    assign coal  = st_valid && coalescable;
    assign push  = st_valid && !stall && !coalescable;
`else
    assign stall = full;
    assign push  = st_valid && !full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                tail_q         <= tail_q + PW'(1);
            end
`ifdef STORE_BUF_COALESCE_EN
            if (coal) data_q[last_idx] <= st_data;
`endif
            if (mem_WE) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(mem_WE);
        end
    end

    sb_fwd_match #(.DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH)) u_fwd (
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (head_q),
        .count      (count_q),
        .ld_addr    (ld_addr),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_store_drain_buffer;
    import store_buf_pkg::*;

    localparam int DEPTH = SB_DEPTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 st_valid;
    logic [SB_ADDR-1:0]   st_addr;
    logic [SB_DATA-1:0]   st_data;
    logic                 stall;
    logic [SB_ADDR-1:0]   ld_addr;
    logic                 fwd_hit;
    logic [SB_DATA-1:0]   fwd_data;
    logic                 mem_grant;
    logic                 mem_WE;
    logic [SB_ADDR-1:0]   mem_A;
    logic [SB_DATA-1:0]   mem_WD;
    logic                 empty;
    logic [$clog2(DEPTH+1)-1:0] count;

    int vectors    = 0;
    int miscompares = 0;
    bit started    = 0;
    bit coal_build;

    sb_entry_t q[$];

    store_drain_buffer #(.DATA(SB_DATA), .ADDR(SB_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .stall(stall),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_grant(mem_grant), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending stores, oldest at the front.
    function automatic bit model_coalesce(input bit draining);
        if (!coal_build) return 0;
        if (!st_valid || q.size() == 0) return 0;
        if (q[q.size()-1].addr != st_addr) return 0;
        if (draining && q.size() == 1) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            bit pop, coal, acc;
            sb_entry_t e;
            pop  = (q.size() > 0) && mem_grant;
            coal = model_coalesce(pop);
            acc  = st_valid && ((q.size() < DEPTH) || coal);
            if (coal) q[q.size()-1].data = st_data;
            if (pop) void'(q.pop_front());
            if (acc && !coal) begin
                e.addr = st_addr;
                e.data = st_data;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit exp_we, exp_hit, exp_stall;
            logic [SB_DATA-1:0] exp_fd;
            exp_we  = (q.size() > 0) && mem_grant;
            exp_hit = 0;
            exp_fd  = '0;
            foreach (q[i]) begin
                if (q[i].addr == ld_addr) begin
                    exp_hit = 1;
                    exp_fd  = q[i].data;
                end
            end
            exp_stall = (q.size() == DEPTH) && !model_coalesce(exp_we);
            chk("m_mem_WE", 32'(mem_WE), 32'(exp_we));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_stall", 32'(stall), 32'(exp_stall));
            chk("m_fwd_hit", 32'(fwd_hit), 32'(exp_hit));
            chk("m_fwd_data", fwd_data, exp_fd);
            if (q.size() > 0) begin
                chk("m_mem_A", mem_A, q[0].addr);
                chk("m_mem_WD", mem_WD, q[0].data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic drain_all();
        mem_grant = 1'b1;
        st_valid  = 1'b0;
        for (int i = 0; i < 12 && empty !== 1'b1; i++) step();
        chk("drain_done", 32'(empty), 32'd1);
    endtask

    initial begin
`ifdef STORE_BUF_COALESCE_EN
        coal_build = 1;
`else
        coal_build = 0;
`endif
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = 32'hFFFF_FFF0; mem_grant = 1'b1;
        step();
        started = 1;
        step();
        rst = 1'b0;
        #1;
        // Reset / empty
        chk("rst_mem_WE", 32'(mem_WE), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        step();

        // Single store: no pass-through, write exactly one cycle later
        store(32'h10, 32'hAA);
        #1;
        chk("single_no_bypass", 32'(mem_WE), 32'd0);
        step();
        st_valid = 1'b0;
        #1;
        chk("single_we", 32'(mem_WE), 32'd1);
        chk("single_A", mem_A, 32'h10);
        chk("single_WD", mem_WD, 32'hAA);
        step();
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_we_off", 32'(mem_WE), 32'd0);

        // Full / stall with in-order drain
        mem_grant = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            store(32'(a), 32'h100 + 32'(a));
            #1;
            chk("full_stall", 32'(stall), 32'(a == 5));
            step();
        end
        mem_grant = 1'b1;
        #1;
        chk("full_stall_drain", 32'(stall), 32'd1);
        chk("full_head1", mem_A, 32'd1);
        step();
        chk("full_cnt3", 32'(count), 32'd3);
        chk("full_unstall", 32'(stall), 32'd0);
        chk("full_head2", mem_A, 32'd2);
        step();
        st_valid = 1'b0;
        #1;
        chk("full_cnt3b", 32'(count), 32'd3);
        for (int e = 3; e <= 5; e++) begin
            chk("full_order_A", mem_A, 32'(e));
            chk("full_order_WD", mem_WD, 32'h100 + 32'(e));
            step();
        end
        chk("full_empty", 32'(empty), 32'd1);

        // Forwarding priority
        mem_grant = 1'b0;
        store(32'h8, 32'h1); step();
        store(32'h8, 32'h2); step();
        store(32'h8, 32'h3);
        ld_addr = 32'h8;
        #1;
        chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_youngest", fwd_data, 32'h2);
        chk("fwd_count", 32'(count), coal_build ? 32'd1 : 32'd2);
        st_valid = 1'b0;
        ld_addr  = 32'h9;
        #1;
        chk("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_miss_data", fwd_data, 32'd0);
        ld_addr   = 32'h8;
        mem_grant = 1'b1;
        #1;
        chk("fwd_head_draining", 32'(fwd_hit), 32'd1);
        drain_all();
        ld_addr = 32'hFFFF_FFF0;

        // Simultaneous accept and drain
        mem_grant = 1'b0;
        store(32'h20, 32'hA0); step();
        store(32'h21, 32'hA1); step();
        store(32'h22, 32'hA2);
        mem_grant = 1'b1;
        #1;
        chk("sim_cnt", 32'(count), 32'd2);
        chk("sim_A0", mem_A, 32'h20);
        step();
        st_valid = 1'b0;
        #1;
        chk("sim_cnt_hold", 32'(count), 32'd2);
        chk("sim_A1", mem_A, 32'h21);
        step();
        chk("sim_A2", mem_A, 32'h22);
        chk("sim_WD2", mem_WD, 32'hA2);
        step();
        chk("sim_empty", 32'(empty), 32'd1);

        // Coalescing (or plain enqueue in the default build)
        mem_grant = 1'b0;
        store(32'h4, 32'h1); step();
        store(32'h4, 32'h7); step();
        st_valid = 1'b0;
        #1;
        chk("coal_count", 32'(count), coal_build ? 32'd1 : 32'd2);
        mem_grant = 1'b1;
        #1;
        chk("coal_A", mem_A, 32'h4);
        chk("coal_WD", mem_WD, coal_build ? 32'h7 : 32'h1);
        step();
        if (!coal_build) begin
            chk("coal_WD2", mem_WD, 32'h7);
            step();
        end
        chk("coal_empty", 32'(empty), 32'd1);

        // Same address as a lone head being drained: enqueued normally
        mem_grant = 1'b0;
        store(32'h4, 32'h7); step();
        store(32'h4, 32'h9);
        mem_grant = 1'b1;
        #1;
        chk("headdrain_we", 32'(mem_WE), 32'd1);
        step();
        st_valid = 1'b0;
        #1;
        chk("headdrain_cnt", 32'(count), 32'd1);
        chk("headdrain_WD", mem_WD, 32'h9);
        step();

        // Matching store while full, then mid-operation reset
        mem_grant = 1'b0;
        for (int a = 0; a < 4; a++) begin
            store(32'h30 + 32'(a), 32'h130 + 32'(a));
            step();
        end
        store(32'h33, 32'h55);
        #1;
        chk("full_coal_stall", 32'(stall), coal_build ? 32'd0 : 32'd1);
        step();
        st_valid = 1'b0;
        ld_addr  = 32'h33;
        #1;
        chk("full_coal_fwd", fwd_data, coal_build ? 32'h55 : 32'h133);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_fwd", 32'(fwd_hit), 32'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Write-through store buffer between the core/cache store path and the single-port data memory. Every store is queued in a small FIFO and drained to data memory whenever the memory port is free, so the core does not wait on memory write bandwidth. Loads check the buffer for a younger pending value to the same word, which keeps read-after-write consistent while stores are still queued. The block is the initiator on the data memory's WE/A/WD write port.

## Interface
- DATA, 32, data word width
- ADDR, 32, word address width, matching data memory A
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from core/cache
- st_addr  in  ADDR  store word address
- st_data  in  DATA  store data
- stall  out  1  buffer cannot accept a store this cycle; core holds st_* stable
- ld_addr  in  ADDR  load address to check for forwarding
- fwd_hit  out  1  a pending entry matches ld_addr
- fwd_data  out  DATA  data of the youngest matching entry; 0 when fwd_hit=0
- mem_grant  in  1  data memory port is free for a write this cycle
- mem_WE  out  1  write enable to data memory
- mem_A  out  ADDR  write address (head entry)
- mem_WD  out  DATA  write data (head entry)
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap naturally, plus a count register.
- **Accept.** A store is accepted when st_valid=1 and stall=0. It is written at tail, and tail increments.
- **Stall.** stall = (count == DEPTH). A full buffer stalls even when a drain happens in the same cycle; there is no full-bypass.
- **Drain.** mem_WE = !empty && mem_grant. mem_A and mem_WD always show the head entry, including when mem_WE=0. On a clock edge with mem_WE=1, head increments.
- **Simultaneous accept and drain.** count is unchanged; both pointers advance.
- **Empty buffer.** A store accepted into an empty buffer is drained no earlier than the next cycle. There is no pass-through to memory.
- **Forwarding.**
  - Purely combinational.
  - All valid entries are compared with ld_addr; the youngest (closest to tail) match wins.
  - The head entry being drained this cycle still counts as valid.
  - The store currently being accepted on st_* is not forwarded.
- **Reset.** Mid-operation, reset discards all pending stores. Software-visible consequence: stores not yet drained are lost.
- **Reset values:**
  - count=0, head=0, tail=0, empty=1, stall=0
  - mem_WE=0, fwd_hit=0, fwd_data=0
  - mem_A and mem_WD are don't-care, driven 0 by storage reset.

## Timing
- Store-to-memory latency: minimum 1 cycle after acceptance with mem_grant=1. The write happens at the second rising edge after st_valid is sampled.
- Throughput: 1 accept and 1 drain per cycle sustained.
- stall is a registered-state function (count only). There is no combinational path from st_valid or mem_grant to stall.
- fwd_hit and fwd_data are combinational from ld_addr and registered state, valid in the same cycle.
- mem_WE depends combinationally on mem_grant. The arbiter must not derive mem_grant from mem_WE.

## Configuration
- Macro: STORE_BUF_COALESCE_EN.
- **Defined:**
  - A store whose st_addr equals the youngest valid entry's address overwrites that entry's data in place; tail and count are unchanged.
  - This is not done when that entry is the head and is being drained this cycle (mem_WE=1). In that case the store is enqueued normally.
  - Coalescing is allowed while full; stall is then forced 0 for that cycle. stall = full && !(st_valid && coalescable), so the stall path depends on st_addr when the macro is defined.
- **Undefined:** every accepted store takes a new entry; stall = full.

## Structure
- Package store_buf_pkg:
  - typedef sb_entry_t {addr[ADDR], data[DATA]}
  - default DATA/ADDR/DEPTH localparams
  - pointer-width function
- Sub-module sb_fwd_match: combinational youngest-match priority search over the entry array, given head and count. Outputs hit and data.

## Test plan
- **Reset/empty.** After rst, with mem_grant=1 and no stores: mem_WE=0, empty=1, count=0, fwd_hit=0.
- **Single store drain.** Store A=0x10, D=0xAA with mem_grant held 1: mem_WE=1 with mem_A=0x10, mem_WD=0xAA exactly one cycle later; empty=1 afterwards.
- **Full/stall.** mem_grant=0, issue 5 stores to A=1..5 with DEPTH=4: stall=1 after the 4th; the 5th is held. Raise mem_grant: drains 1,2,3,4, then 5, in order.
- **Forwarding priority.** mem_grant=0, stores (A=8,D=1) then (A=8,D=2), ld_addr=8: fwd_hit=1, fwd_data=2. ld_addr=9: fwd_hit=0.
- **Simultaneous accept and drain.** count=2, st_valid=1 and mem_grant=1 in the same cycle: count stays 2; order is preserved.
- **Coalesce, macro defined.** mem_grant=0, stores (A=4,D=1) then (A=4,D=7): count=1. After mem_grant=1, a single write A=4, D=7.
